// File: rtl/rv32_mem_pkg.sv
// ----------------------------------------------------------------------------
// rv32_mem_pkg
// Shared definitions for the RV32 memory arbiter slice.
//   arb_state_e            : arbiter FSM state (idle / instruction / data owner)
//   DEFAULT_TIMEOUT_CYCLES : default bus watchdog limit in cycles
// ----------------------------------------------------------------------------
package rv32_mem_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_e;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage : rv32_mem_pkg

// File: rtl/rv32_bus_watchdog.sv
// ----------------------------------------------------------------------------
// rv32_bus_watchdog
// Counts cycles a bus transaction has been waiting and flags when the limit
// is reached.
//   clk          : clock
//   reset        : synchronous, active-high
//   clear        : restart the count (asserted on every new grant)
//   count_enable : count this cycle (transaction busy, bus not ready)
//   expired      : count has reached TIMEOUT_CYCLES
// ----------------------------------------------------------------------------
module rv32_bus_watchdog
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_enable,
    output logic expired
);

    // A zero limit would give a zero-width counter; keep at least one bit.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count_q;

    assign expired = (count_q == LIMIT);

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (count_enable && !expired) begin
            // Saturate at the limit so the counter never wraps back to zero.
            count_q <= count_q + 1'b1;
        end
    end

endmodule : rv32_bus_watchdog

// File: rtl/rv32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv32_mem_arbiter
// Shares one memory bus between an instruction-fetch port and a data port.
// Data requests win when both are pending in idle; after a completion only the
// other requester is considered, which allows back-to-back transactions.
// A watchdog completes a stuck transaction with a fault flag.
//   clk, reset              : clock, synchronous active-high reset
//   instr_*                 : fetch request in, ready/value/fault out
//   data_*                  : load/store request in, ready/value/fault out
//   bus_*_out               : registered bus command, stable per transaction
//   bus_read_value_in       : read data returned by the bus
//   bus_ready_in            : transaction complete (ignored in idle)
// ----------------------------------------------------------------------------
module rv32_mem_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        instr_read_in,
    input  logic [31:0] instr_address_in,
    output logic        instr_ready_out,
    output logic [31:0] instr_read_value_out,
    output logic        instr_fault_out,

    input  logic        data_read_in,
    input  logic        data_write_in,
    input  logic [31:0] data_address_in,
    input  logic [3:0]  data_write_mask_in,
    input  logic [31:0] data_write_value_in,
    output logic        data_ready_out,
    output logic [31:0] data_read_value_out,
    output logic        data_fault_out,

    output logic [31:0] bus_address_out,
    output logic        bus_read_out,
    output logic        bus_write_out,
    output logic [3:0]  bus_write_mask_out,
    output logic [31:0] bus_write_value_out,
    input  logic [31:0] bus_read_value_in,
    input  logic        bus_ready_in
);

    arb_state_e  state_q;
    logic [31:0] bus_address_q;
    logic        bus_read_q;
    logic        bus_write_q;
    logic [3:0]  bus_write_mask_q;
    logic [31:0] bus_write_value_q;

    logic busy;
    logic data_req;
    logic txn_done;
    logic txn_fault;
    logic grant_data;
    logic grant_instr;
    logic wd_expired;

    rv32_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (clk),
        .reset        (reset),
        .clear        (grant_data | grant_instr),
        .count_enable (busy & ~bus_ready_in),
        .expired      (wd_expired)
    );

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        busy        = (state_q != ARB_IDLE);
        data_req    = data_read_in | data_write_in;
        txn_done    = busy & (bus_ready_in | wd_expired);
        // A real bus_ready in the expiry cycle counts as a normal completion.
        txn_fault   = busy & ~bus_ready_in & wd_expired;
        grant_data  = 1'b0;
        grant_instr = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                grant_data  = data_req;
                grant_instr = ~data_req & instr_read_in;
            end
            // The completing requester's own line is stale this cycle, so
            // only the other side is eligible for the follow-on grant.
            ARB_INSTR: grant_data  = txn_done & data_req;
            ARB_DATA:  grant_instr = txn_done & instr_read_in;
            default: ;
        endcase
    end

    always_comb begin
        instr_ready_out      = ~reset & (state_q == ARB_INSTR) & txn_done;
        data_ready_out       = ~reset & (state_q == ARB_DATA)  & txn_done;
        instr_fault_out      = instr_ready_out & txn_fault;
        data_fault_out       = data_ready_out  & txn_fault;
        instr_read_value_out = (instr_ready_out & ~txn_fault) ? bus_read_value_in : 32'h0;
        data_read_value_out  = (data_ready_out  & ~txn_fault) ? bus_read_value_in : 32'h0;
    end

    // Bus command registers are loaded only on a grant, so requester inputs
    // may change or drop mid-transaction without disturbing the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ARB_IDLE;
            bus_address_q     <= '0;
            bus_read_q        <= 1'b0;
            bus_write_q       <= 1'b0;
            bus_write_mask_q  <= '0;
            bus_write_value_q <= '0;
        end else if (grant_data) begin
            state_q           <= ARB_DATA;
            bus_address_q     <= data_address_in;
            // Read and write together resolve to a write.
            bus_read_q        <= data_read_in & ~data_write_in;
            bus_write_q       <= data_write_in;
            bus_write_mask_q  <= data_write_in ? data_write_mask_in  : 4'h0;
            bus_write_value_q <= data_write_in ? data_write_value_in : 32'h0;
        end else if (grant_instr) begin
            state_q           <= ARB_INSTR;
            bus_address_q     <= instr_address_in;
            bus_read_q        <= 1'b1;
            bus_write_q       <= 1'b0;
            bus_write_mask_q  <= '0;
            bus_write_value_q <= '0;
        end else if (txn_done) begin
            state_q           <= ARB_IDLE;
            bus_read_q        <= 1'b0;
            bus_write_q       <= 1'b0;
        end
    end

    assign bus_address_out     = bus_address_q;
    assign bus_read_out        = bus_read_q;
    assign bus_write_out       = bus_write_q;
    assign bus_write_mask_out  = bus_write_mask_q;
    assign bus_write_value_out = bus_write_value_q;

endmodule : rv32_mem_arbiter

// File: tb/tb_rv32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32_mem_arbiter
// Directed scenarios plus a randomized run against a transaction-level model.
// ----------------------------------------------------------------------------
module tb_rv32_mem_arbiter;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        instr_read_in;
    logic [31:0] instr_address_in;
    logic        instr_ready_out;
    logic [31:0] instr_read_value_out;
    logic        instr_fault_out;
    logic        data_read_in;
    logic        data_write_in;
    logic [31:0] data_address_in;
    logic [3:0]  data_write_mask_in;
    logic [31:0] data_write_value_in;
    logic        data_ready_out;
    logic [31:0] data_read_value_out;
    logic        data_fault_out;
    logic [31:0] bus_address_out;
    logic        bus_read_out;
    logic        bus_write_out;
    logic [3:0]  bus_write_mask_out;
    logic [31:0] bus_write_value_out;
    logic [31:0] bus_read_value_in;
    logic        bus_ready_in;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the bus, how long it has waited, and the
    // command captured when it was granted.
    int          m_owner;   // 0 none, 1 instruction, 2 data
    int          m_waited;
    logic        m_rd, m_wr;
    logic [31:0] m_addr, m_wval;
    logic [3:0]  m_mask;

    rv32_mem_arbiter #(
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .instr_read_in        (instr_read_in),
        .instr_address_in     (instr_address_in),
        .instr_ready_out      (instr_ready_out),
        .instr_read_value_out (instr_read_value_out),
        .instr_fault_out      (instr_fault_out),
        .data_read_in         (data_read_in),
        .data_write_in        (data_write_in),
        .data_address_in      (data_address_in),
        .data_write_mask_in   (data_write_mask_in),
        .data_write_value_in  (data_write_value_in),
        .data_ready_out       (data_ready_out),
        .data_read_value_out  (data_read_value_out),
        .data_fault_out       (data_fault_out),
        .bus_address_out      (bus_address_out),
        .bus_read_out         (bus_read_out),
        .bus_write_out        (bus_write_out),
        .bus_write_mask_out   (bus_write_mask_out),
        .bus_write_value_out  (bus_write_value_out),
        .bus_read_value_in    (bus_read_value_in),
        .bus_ready_in         (bus_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        instr_read_in       = 1'b0;
        instr_address_in    = 32'h0;
        data_read_in        = 1'b0;
        data_write_in       = 1'b0;
        data_address_in     = 32'h0;
        data_write_mask_in  = 4'h0;
        data_write_value_in = 32'h0;
        bus_read_value_in   = 32'h0;
        bus_ready_in        = 1'b0;
    endtask

    task automatic test_reset;
        // Requests and bus_ready active while reset is held.
        reset = 1'b1;
        instr_read_in = 1'b1;
        data_read_in = 1'b1;
        bus_ready_in = 1'b1;
        bus_read_value_in = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({instr_ready_out, instr_fault_out, instr_read_value_out,
             data_ready_out, data_fault_out, data_read_value_out} !== 68'h0) begin
            errors++;
            $display("FAIL reset_responses: got %h expected 0",
                     {instr_ready_out, instr_fault_out, instr_read_value_out,
                      data_ready_out, data_fault_out, data_read_value_out});
        end
        checks++;
        if ({bus_address_out, bus_read_out, bus_write_out, bus_write_mask_out,
             bus_write_value_out} !== 70'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h expected 0",
                     {bus_address_out, bus_read_out, bus_write_out,
                      bus_write_mask_out, bus_write_value_out});
        end
        next_cycle();
        // Idle with no request: stays idle and ignores bus_ready.
        reset = 1'b0;
        idle_inputs();
        bus_ready_in = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus_read_out, bus_write_out, instr_ready_out, data_ready_out} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ignores_ready: got %b expected 0000",
                     {bus_read_out, bus_write_out, instr_ready_out, data_ready_out});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_instr_read;
        instr_read_in = 1'b1;
        instr_address_in = 32'h0000_0100;
        @(negedge clk);
        checks++;
        if (bus_read_out !== 1'b0) begin
            errors++;
            $display("FAIL instr_no_early_grant: got %b expected 0", bus_read_out);
        end
        next_cycle();
        // Bus cycle 1
        @(negedge clk);
        checks++;
        if ({bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out,
             bus_write_value_out, instr_ready_out} !== {1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL instr_grant: got %h expected %h",
                     {bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out,
                      bus_write_value_out, instr_ready_out},
                     {1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0});
        end
        next_cycle();
        // Bus cycle 2
        next_cycle();
        // Bus cycle 3: completion
        bus_ready_in = 1'b1;
        bus_read_value_in = 32'h0000_0013;
        instr_read_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({instr_ready_out, instr_fault_out, instr_read_value_out, data_ready_out}
                !== {1'b1, 1'b0, 32'h13, 1'b0}) begin
            errors++;
            $display("FAIL instr_complete: got %h expected %h",
                     {instr_ready_out, instr_fault_out, instr_read_value_out, data_ready_out},
                     {1'b1, 1'b0, 32'h13, 1'b0});
        end
        next_cycle();
        bus_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_read_out, instr_ready_out, instr_read_value_out} !== 34'h0) begin
            errors++;
            $display("FAIL instr_after: got %h expected 0",
                     {bus_read_out, instr_ready_out, instr_read_value_out});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        instr_read_in = 1'b1;
        instr_address_in = 32'h0000_0200;
        data_write_in = 1'b1;
        data_address_in = 32'h0000_8000;
        data_write_mask_in = 4'hF;
        data_write_value_in = 32'hDEAD_BEEF;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus_write_out, bus_read_out, bus_address_out, bus_write_mask_out, bus_write_value_out}
                !== {1'b1, 1'b0, 32'h8000, 4'hF, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL b2b_data_first: got %h expected %h",
                     {bus_write_out, bus_read_out, bus_address_out, bus_write_mask_out, bus_write_value_out},
                     {1'b1, 1'b0, 32'h8000, 4'hF, 32'hDEAD_BEEF});
        end
        next_cycle();
        // Completion; data_write_in is still (stale) high.
        bus_ready_in = 1'b1;
        bus_read_value_in = 32'h0;
        @(negedge clk);
        checks++;
        if ({data_ready_out, data_fault_out, instr_ready_out} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_data_done: got %b expected 100",
                     {data_ready_out, data_fault_out, instr_ready_out});
        end
        next_cycle();
        data_write_in = 1'b0;
        bus_ready_in = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out, bus_write_value_out}
                !== {1'b1, 1'b0, 32'h200, 4'h0, 32'h0}) begin
            errors++;
            $display("FAIL b2b_instr_next: got %h expected %h",
                     {bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out, bus_write_value_out},
                     {1'b1, 1'b0, 32'h200, 4'h0, 32'h0});
        end
        next_cycle();
        bus_ready_in = 1'b1;
        bus_read_value_in = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({instr_ready_out, instr_read_value_out, data_ready_out} !== {1'b1, 32'h1234_5678, 1'b0}) begin
            errors++;
            $display("FAIL b2b_instr_done: got %h expected %h",
                     {instr_ready_out, instr_read_value_out, data_ready_out},
                     {1'b1, 32'h1234_5678, 1'b0});
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_timeout;
        data_read_in = 1'b1;
        data_address_in = 32'h0000_0040;
        next_cycle();
        // Requester drops its request; the bus keeps waiting.
        data_read_in = 1'b0;
        bus_read_value_in = 32'hFFFF_FFFF;
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            @(negedge clk);
            checks++;
            if ({bus_read_out, data_ready_out, data_fault_out} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_wait%0d: got %b expected 100",
                         k, {bus_read_out, data_ready_out, data_fault_out});
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if ({data_ready_out, data_fault_out, data_read_value_out, instr_ready_out, instr_fault_out}
                !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL timeout_fault: got %h expected %h",
                     {data_ready_out, data_fault_out, data_read_value_out, instr_ready_out, instr_fault_out},
                     {1'b1, 1'b1, 32'h0, 1'b0, 1'b0});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus_read_out, bus_write_out, data_ready_out, data_fault_out} !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_idle: got %b expected 0000",
                     {bus_read_out, bus_write_out, data_ready_out, data_fault_out});
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        data_write_in = 1'b1;
        data_address_in = 32'h0000_0400;
        data_write_mask_in = 4'h1;
        data_write_value_in = 32'h55;
        next_cycle();
        @(negedge clk);
        checks++;
        if (bus_write_out !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: got %b expected 1", bus_write_out);
        end
        next_cycle();
        reset = 1'b1;
        bus_ready_in = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_ready_out, data_fault_out, data_read_value_out} !== 34'h0) begin
            errors++;
            $display("FAIL rstmid_no_pulse: got %h expected 0",
                     {data_ready_out, data_fault_out, data_read_value_out});
        end
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        instr_read_in = 1'b1;
        instr_address_in = 32'h0000_0300;
        @(negedge clk);
        checks++;
        if ({bus_write_out, bus_read_out} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_strobes: got %b expected 00", {bus_write_out, bus_read_out});
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if ({bus_read_out, bus_address_out} !== {1'b1, 32'h300}) begin
            errors++;
            $display("FAIL rstmid_regrant: got %h expected %h",
                     {bus_read_out, bus_address_out}, {1'b1, 32'h300});
        end
        next_cycle();
        instr_read_in = 1'b0;
        bus_ready_in = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_conflict_flush;
        data_read_in = 1'b1;
        data_write_in = 1'b1;
        data_address_in = 32'h0000_9000;
        data_write_mask_in = 4'h3;
        data_write_value_in = 32'hA5A5_5A5A;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            // Flush: the request vanishes and the inputs wander.
            if (k > 0) begin
                data_read_in = 1'b0;
                data_write_in = 1'b0;
                data_address_in = $urandom;
                data_write_mask_in = 4'($urandom);
                data_write_value_in = $urandom;
            end
            @(negedge clk);
            checks++;
            if ({bus_write_out, bus_read_out, bus_address_out, bus_write_mask_out,
                 bus_write_value_out, data_ready_out}
                    !== {1'b1, 1'b0, 32'h9000, 4'h3, 32'hA5A5_5A5A, 1'b0}) begin
                errors++;
                $display("FAIL conflict_hold%0d: got %h expected %h", k,
                         {bus_write_out, bus_read_out, bus_address_out, bus_write_mask_out,
                          bus_write_value_out, data_ready_out},
                         {1'b1, 1'b0, 32'h9000, 4'h3, 32'hA5A5_5A5A, 1'b0});
            end
            next_cycle();
        end
        bus_ready_in = 1'b1;
        bus_read_value_in = 32'h0BAD_F00D;
        @(negedge clk);
        checks++;
        if ({data_ready_out, data_fault_out, data_read_value_out} !== {1'b1, 1'b0, 32'h0BAD_F00D}) begin
            errors++;
            $display("FAIL flush_pulse: got %h expected %h",
                     {data_ready_out, data_fault_out, data_read_value_out},
                     {1'b1, 1'b0, 32'h0BAD_F00D});
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic model_reset;
        m_owner  = 0;
        m_waited = 0;
        m_rd     = 1'b0;
        m_wr     = 1'b0;
        m_addr   = 32'h0;
        m_mask   = 4'h0;
        m_wval   = 32'h0;
    endtask

    task automatic test_random;
        logic [69:0] got, exp;
        logic        m_busy, m_done, m_tout, dreq;
        logic [31:0] exp_val;
        int          nxt;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            reset               = ($urandom_range(0, 96) == 0);
            instr_read_in       = ($urandom_range(0, 2) != 0);
            instr_address_in    = $urandom;
            data_read_in        = ($urandom_range(0, 3) == 0);
            data_write_in       = ($urandom_range(0, 3) == 0);
            data_address_in     = $urandom;
            data_write_mask_in  = 4'($urandom);
            data_write_value_in = $urandom;
            bus_ready_in        = ($urandom_range(0, 2) == 0);
            bus_read_value_in   = $urandom;

            dreq    = data_read_in | data_write_in;
            m_busy  = (m_owner != 0);
            m_done  = m_busy && (bus_ready_in || m_waited >= TB_TIMEOUT);
            m_tout  = m_done && !bus_ready_in;
            exp_val = m_tout ? 32'h0 : bus_read_value_in;
            exp = {(!reset && m_owner == 1 && m_done), (!reset && m_owner == 1 && m_tout),
                   (!reset && m_owner == 1 && m_done) ? exp_val : 32'h0,
                   (!reset && m_owner == 2 && m_done), (!reset && m_owner == 2 && m_tout),
                   (!reset && m_owner == 2 && m_done) ? exp_val : 32'h0,
                   m_rd, m_wr};

            @(negedge clk);
            got = {instr_ready_out, instr_fault_out, instr_read_value_out,
                   data_ready_out, data_fault_out, data_read_value_out,
                   bus_read_out, bus_write_out};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rand_resp cycle %0d: got %h expected %h", n, got, exp);
            end
            if (m_owner != 0) begin
                checks++;
                if (bus_address_out !== m_addr) begin
                    errors++;
                    $display("FAIL rand_addr cycle %0d: got %h expected %h", n, bus_address_out, m_addr);
                end
            end
            if (m_wr || m_owner == 1) begin
                checks++;
                if ({bus_write_mask_out, bus_write_value_out} !== {m_mask, m_wval}) begin
                    errors++;
                    $display("FAIL rand_wdata cycle %0d: got %h expected %h", n,
                             {bus_write_mask_out, bus_write_value_out}, {m_mask, m_wval});
                end
            end

            // Advance the model by one clock edge.
            if (reset) begin
                model_reset();
            end else begin
                nxt = 0;
                if (m_owner == 0)      nxt = dreq ? 2 : (instr_read_in ? 1 : 0);
                else if (m_owner == 1) nxt = (m_done && dreq) ? 2 : 0;
                else                   nxt = (m_done && instr_read_in) ? 1 : 0;
                if (nxt == 2) begin
                    m_owner  = 2;
                    m_waited = 0;
                    m_addr   = data_address_in;
                    m_rd     = data_read_in && !data_write_in;
                    m_wr     = data_write_in;
                    m_mask   = data_write_in ? data_write_mask_in : 4'h0;
                    m_wval   = data_write_in ? data_write_value_in : 32'h0;
                end else if (nxt == 1) begin
                    m_owner  = 1;
                    m_waited = 0;
                    m_addr   = instr_address_in;
                    m_rd     = 1'b1;
                    m_wr     = 1'b0;
                    m_mask   = 4'h0;
                    m_wval   = 32'h0;
                end else if (m_done) begin
                    m_owner = 0;
                    m_rd    = 1'b0;
                    m_wr    = 1'b0;
                end else if (m_busy && !bus_ready_in) begin
                    m_waited++;
                end
            end
            next_cycle();
        end
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) next_cycle();
        test_reset();
        test_instr_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_conflict_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rv32_mem_arbiter
